// File: rtl/drum_arbiter.sv
// rtl/drum_arbiter.sv - two-requester round-robin front end sharing one DRUM approximate multiplier
// Operands and products are ones'-complement signed; one product in flight at a time.

module drum #(
  parameter int K = 6,
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] r
);

  logic [N-1:0]   ma, ta;
  logic [M-1:0]   mb, tb;
  logic [N+M-1:0] prod;
  int             lead_a, lead_b, sha, shb;

  // Magnitudes wider than K bits keep their top K bits with the LSB forced
  // to 1, which centres the truncation error around zero.
  always_comb begin
    ma = a[N-1] ? ~a : a;
    mb = b[M-1] ? ~b : b;
    lead_a = 0;
    lead_b = 0;
    for (int i = 0; i < N; i++)
      if (ma[i]) lead_a = i;
    for (int i = 0; i < M; i++)
      if (mb[i]) lead_b = i;
    sha = (lead_a >= K) ? lead_a - K + 1 : 0;
    shb = (lead_b >= K) ? lead_b - K + 1 : 0;
    ta = ma >> sha;
    tb = mb >> shb;
    if (sha != 0) ta[0] = 1'b1;
    if (shb != 0) tb[0] = 1'b1;
    prod = ({{M{1'b0}}, ta} * {{N{1'b0}}, tb}) << (sha + shb);
    r = (a[N-1] ^ b[M-1]) ? ~prod : prod;
  end

endmodule

module drum_arbiter #(
  parameter int W = 8,
  parameter int K = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           res_id,
  output logic [2*W-1:0] res_r,
  output logic [15:0]    op_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state;
  logic           ptr;
  logic           gnt0, gnt1;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] prod;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (req0_valid && (!req1_valid || !ptr)) gnt0 = 1'b1;
      else if (req1_valid)                     gnt1 = 1'b1;
    end
    op_a = '0;
    op_b = '0;
    if (gnt0) begin
      op_a = req0_a;
      op_b = req0_b;
    end else if (gnt1) begin
      op_a = req1_a;
      op_b = req1_b;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  drum #(.K(K), .N(W), .M(W)) u_drum (
    .a (op_a),
    .b (op_b),
    .r (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_r     <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            state     <= HOLD;
            res_valid <= 1'b1;
            res_r     <= prod;
            res_id    <= gnt1;
            ptr       <= gnt0;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_arbiter.sv
// tb/tb_drum_arbiter.sv - scoreboard bench for drum_arbiter with a DRUM reference model
// Driver predicts grants and pushes expected products; monitor pops on each delivery.

module tb_drum_arbiter;

  localparam int W = 8;
  localparam int K = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         res_valid, res_ready = 1'b0, res_id;
  logic [15:0]  res_r, op_count;

  typedef struct {
    logic        id;
    logic [15:0] r;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_ptr = 1'b0;
  logic        m_busy = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  drum_arbiter #(.W(W), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_r      (res_r),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  function automatic longint approx(longint m);
    int t;
    int sh;
    if (m < (64'd1 << K)) return m;
    t = 0;
    while ((m >> (t + 1)) != 0) t++;
    sh = t - K + 1;
    return ((m >> sh) | 1) << sh;
  endfunction

  function automatic logic [15:0] drum_model(logic [7:0] a, logic [7:0] b);
    longint ma, mb, p;
    ma = a[7] ? (255 - longint'(a)) : longint'(a);
    mb = b[7] ? (255 - longint'(b)) : longint'(b);
    p  = approx(ma) * approx(mb);
    if (a[7] ^ b[7]) p = 65535 - p;
    return p[15:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; checks DUT against the model at #1 after negedge.
  task automatic cycle(bit v0, logic [7:0] a0, logic [7:0] b0,
                       bit v1, logic [7:0] a1, logic [7:0] b1, bit rdy);
    int   win;
    exp_t e;
    @(negedge clk);
    rst        = 1'b0;
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    res_ready  = rdy;
    #1;
    win = -1;
    if (!m_busy) begin
      if (v0 && v1) win = int'(m_ptr);
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    chk("req0_ready", req0_ready, (win == 0));
    chk("req1_ready", req1_ready, (win == 1));
    chk("res_valid", res_valid, m_busy);
    chk("op_count", op_count, m_cnt);
    if (m_busy && q.size() > 0) begin
      chk("hold_r", res_r, q[0].r);
      chk("hold_id", res_id, q[0].id);
    end
    if (win >= 0) begin
      e.id = (win == 1);
      e.r  = (win == 1) ? drum_model(a1, b1) : drum_model(a0, b0);
      q.push_back(e);
      m_ptr  = (win == 0);
      m_busy = 1'b1;
    end else if (m_busy && rdy) begin
      m_busy = 1'b0;
      m_cnt  = m_cnt + 16'd1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL deliver_unexpected: got id %0d r %0h expected none", res_id, res_r);
        end else begin
          e = q.pop_front();
          chk("deliver_r", res_r, e.r);
          chk("deliver_id", res_id, e.id);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] a0, b0, a1, b1;
    bit         v0, v1, rdy;

    // Reset state with both requesters already offering
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #3;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_r", res_r, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_op_count", op_count, 0);

    // Grant in first cycle after reset release, exact small product
    cycle(1, 8'd5, 8'd7, 0, 8'd0, 8'd0, 1);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
    chk("r_5x7", res_r, 16'h0023);
    chk("id_5x7", res_id, 0);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
    chk("count_after_1", op_count, 16'd1);

    cycle(1, 8'hFA, 8'd7, 0, 8'd0, 8'd0, 1);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
    chk("r_neg", res_r, 16'hFFDC);
    cycle(1, 8'hFA, 8'hF8, 0, 8'd0, 8'd0, 1);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
    chk("r_negneg", res_r, 16'h0023);

    // Both valid continuously: alternation checked through the scoreboard
    for (int i = 0; i < 12; i++)
      cycle(1, 8'(i), 8'd100, 1, 8'd120, 8'(i + 3), 1);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);

    // Back-pressure for five cycles, then a single delivery
    cycle(1, 8'd90, 8'd77, 0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 5; i++)
      cycle(1, 8'd3, 8'd4, 1, 8'd5, 8'd6, 0);
    cycle(1, 8'd3, 8'd4, 1, 8'd5, 8'd6, 1);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);

    // Reset while holding a result: pointer was left at 1 by a req0 grant
    cycle(1, 8'd9, 8'd9, 0, 8'd0, 8'd0, 0);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("hold_rst_res_valid", res_valid, 0);
    chk("hold_rst_op_count", op_count, 0);
    q.delete();
    m_busy = 1'b0;
    m_ptr  = 1'b0;
    m_cnt  = 16'd0;
    cycle(1, 8'd2, 8'd3, 1, 8'd4, 8'd5, 1);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
    chk("post_rst_id", res_id, 0);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v0  = ($urandom_range(0, 99) < 55);
      v1  = ($urandom_range(0, 99) < 55);
      rdy = ($urandom_range(0, 99) < 65);
      a0  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom);
      b0  = 8'($urandom);
      a1  = 8'($urandom);
      b1  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(192, 255)) : 8'($urandom);
      cycle(v0, a0, b0, v1, a1, b1, rdy);
    end
    for (int i = 0; i < 3; i++)
      cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);

    // Counter wrap from 16'hFFFF
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    m_cnt = 16'hFFFF;
    cycle(1, 8'd1, 8'd1, 0, 8'd0, 8'd0, 1);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
    cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
    chk("op_count_wrap", op_count, 16'h0000);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drum_arbiter.md
DRUM_ARBITER -- requirements
Module: drum_arbiter

Interface
REQ-001 Parameter: W, default 8, operand width in bits for both operands.
REQ-002 Parameter: K, default 6, DRUM truncation width passed to the shared drum datapath.
REQ-003 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-high reset.
REQ-005 Port: req0_valid, input, 1, requester 0 offers an operand pair.
REQ-006 Port: req0_ready, output, 1, requester 0 pair accepted this cycle.
REQ-007 Port: req0_a / req0_b, input, W each, requester 0 operands (ones'-complement signed).
REQ-008 Port: req1_valid / req1_ready / req1_a / req1_b, same as REQ-005..007 for requester 1.
REQ-009 Port: res_valid, output, 1, result register holds an undelivered product.
REQ-010 Port: res_ready, input, 1, consumer accepts the result.
REQ-011 Port: res_id, output, 1, index of the requester that owns the result.
REQ-012 Port: res_r, output, 2W, approximate product.
REQ-013 Port: op_count, output, 16, number of products delivered since reset.

Function
REQ-014 One drum datapath instance (k=K, n=W, m=W) SHALL be shared; it SHALL be driven only by the granted requester's operands.
REQ-015 FSM states SHALL be IDLE (result register empty) and HOLD (result register full).
- IDLE: grant when either valid is high; move to HOLD.
- HOLD: stay while !res_ready; on res_ready return to IDLE.
REQ-016 Grants SHALL occur only in IDLE; reqN_ready SHALL be high exactly in the IDLE cycle that grants requester N, and combinationally low otherwise.
REQ-017 Handshake: transfer on reqN_valid && reqN_ready; at most one requester SHALL be ready per cycle.
REQ-018 Arbitration SHALL be round-robin with a 1-bit priority pointer, reset value 0.
- Only one valid: that requester wins regardless of pointer.
- Both valid: pointer holder wins.
- After any grant to N, pointer becomes !N.
REQ-019 Latency: the grant in cycle t SHALL produce res_valid=1 with res_r, res_id registered at the edge ending cycle t; the result is visible in cycle t+1.
REQ-020 res_r SHALL equal the drum output for the granted a, b, zero-extended to 2W bits.
- Magnitude below 2^K: exact product.
- Negative operand: bitwise-inverted magnitude.
- Negative product: inverted result.
REQ-021 While res_valid && !res_ready, res_r and res_id SHALL hold stable.
REQ-022 When res_valid && res_ready, res_valid SHALL drop next cycle and the next grant SHALL occur no earlier than that IDLE cycle (max throughput one product per 2 cycles).
REQ-023 op_count SHALL increment by 1 on every res_valid && res_ready and wrap from 16'hFFFF to 0.
REQ-024 Requester valid deassertion without handshake SHALL be legal and SHALL leave the pointer unchanged.
REQ-025 res_ready while res_valid=0 SHALL have no effect.

Reset
REQ-026 rst high SHALL asynchronously force: state=IDLE, res_valid=0, res_r=0, res_id=0, pointer=0, op_count=0; req0_ready/req1_ready=0 while rst is high.
REQ-027 Reset during HOLD SHALL discard the pending result without a delivery or count increment.
REQ-028 First grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-029 W=8, K=6: req0 a=5, b=7, res_ready=1 -> res_valid next cycle, res_r=16'h0023, res_id=0, op_count=1.
REQ-030 req0 a=8'hFA, b=7 -> res_r=16'hFFDC; a=8'hFA, b=8'hF8 -> res_r=16'h0023.
REQ-031 Both valid continuously, res_ready=1 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; one result every 2 cycles.
REQ-032 res_ready=0 for 5 cycles after result -> res_r/res_id stable, both reqN_ready=0, op_count unchanged; then res_ready=1 -> single delivery.
REQ-033 rst pulsed in HOLD -> res_valid=0 immediately, op_count=0, pointer=0; next both-valid grant goes to req0.
REQ-034 Preload 65535 deliveries (or force op_count) -> next delivery wraps op_count to 0.
